// File: rtl/operand_collector_if.sv
// Handshake bundle between an operand source, the operand collector and the
// m-operand fast adder that consumes the packed group.
interface operand_collector_if #(
    parameter int m = 5,
    parameter int n = 64
);
    localparam int CW = $clog2(m + 1);

    // Upstream beat channel
    logic            in_valid;
    logic            in_ready;
    logic [n-1:0]    in_data;
    logic            in_last;
    logic            in_c;

    // Downstream packed-group channel
    logic            out_valid;
    logic            out_ready;
    logic [m*n-1:0]  x;
    logic            c;
    logic [CW-1:0]   count;

    // Operand source and adder side
    modport master (
        output in_valid, in_data, in_last, in_c, out_ready,
        input  in_ready, out_valid, x, c, count
    );

    // Collector side
    modport slave (
        input  in_valid, in_data, in_last, in_c, out_ready,
        output in_ready, out_valid, x, c, count
    );
endinterface

// File: rtl/operand_collector.sv
// Serial-to-parallel operand buffer: packs up to m n-bit beats into the flat
// m*n-bit bus of the fast adder and holds the group until it is taken.
module operand_collector #(
    parameter int m = 5,
    parameter int n = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_collector_if.slave   bus
);
    localparam int CW = $clog2(m + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_out_valid;
    logic            r_c;
    logic [CW-1:0]   r_count;
    logic [n-1:0]    r_slot [m];

    logic            w_in_ready;
    logic            w_accept;
    logic            w_close;
    logic [m*n-1:0]  w_x;

    assign w_in_ready = ~r_out_valid;
    assign w_accept   = bus.in_valid & w_in_ready;
    // The m-th beat closes the group whether or not in_last is set.
    assign w_close    = (r_count == CW'(m - 1)) | bus.in_last;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned; a missed path would infer a latch.
    always_comb begin
        w_x = '0;
        for (int k = 0; k < m; k++) begin
            w_x[k*n +: n] = r_slot[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_out_valid <= 1'b0;
            r_c         <= 1'b0;
            r_count     <= '0;
            // NOTE: the slot storage is reset, not just the count, because
            // slots a short group never writes must read back as zero padding.
            for (int k = 0; k < m; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < m; k++) begin
                            if (r_count == CW'(k)) begin
                                r_slot[k] <= bus.in_data;
                            end
                        end
                        r_count <= r_count + CW'(1);
                        if (w_close) begin
                            r_c         <= bus.in_c;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Release wipes the group so the next fill starts zero-padded.
                    if (bus.out_ready) begin
                        for (int k = 0; k < m; k++) begin
                            r_slot[k] <= '0;
                        end
                        r_count     <= '0;
                        r_c         <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= FILL;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.x         = w_x;
    assign bus.c         = r_c;
    assign bus.count     = r_count;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with m=5, n=8: full and short groups,
// backpressure, reset mid-fill and in HOLD, and back-to-back throughput.
module tb_operand_collector;
    localparam int M = 5;
    localparam int N = 8;
    localparam int GROUPS = 20;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    operand_collector_if #(.m(M), .n(N)) bus ();

    operand_collector #(.m(M), .n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [N-1:0] data,
                         input logic last, input logic cin);
        bus.in_valid = valid;
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_c     = cin;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({tag, "_x"},         64'(bus.x),         64'd0);
        check({tag, "_count"},     64'(bus.count),     64'd0);
        check({tag, "_c"},         64'(bus.c),         64'd0);
    endtask

    logic [N-1:0]   beats [0:M*GROUPS];
    logic [M*N-1:0] exp_x;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_idle("reset");

        // Full group 0x01..0x05, carry on beat 5, out_ready already high in FILL
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h01, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h02, 1'b0, 1'b0); tick();
        check("full_count2",     64'(bus.count),     64'd2);
        check("full_outv_fill",  64'(bus.out_valid), 64'd0);
        drive(1'b1, 8'h03, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h04, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h05, 1'b0, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        check("full_in_ready",  64'(bus.in_ready),  64'd0);
        check("full_x",         64'(bus.x),         64'h0504030201);
        check("full_c",         64'(bus.c),         64'd1);
        check("full_count",     64'(bus.count),     64'd5);
        tick();
        check_idle("full_release");

        // Short group: carry set on the non-closing beat must be ignored
        bus.out_ready = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, 1'b1); tick();
        drive(1'b1, 8'hBB, 1'b1, 1'b0); tick();
        check("short_out_valid", 64'(bus.out_valid), 64'd1);
        check("short_x",         64'(bus.x),         64'h000000BBAA);
        check("short_count",     64'(bus.count),     64'd2);
        check("short_c",         64'(bus.c),         64'd0);

        // Backpressure: changing beats with closing flags must not disturb HOLD
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b1, 1'b1);
            tick();
            check("bp_x",        64'(bus.x),         64'h000000BBAA);
            check("bp_count",    64'(bus.count),     64'd2);
            check("bp_c",        64'(bus.c),         64'd0);
            check("bp_in_ready", 64'(bus.in_ready),  64'd0);
            check("bp_out_valid",64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        check_idle("bp_release");
        tick();
        check("bp_first_count", 64'(bus.count),     64'd1);
        check("bp_first_x",     64'(bus.x),         64'h0000000077);
        check("bp_first_outv",  64'(bus.out_valid), 64'd0);
        drive(1'b1, 8'h78, 1'b1, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("bp_group_x",     64'(bus.x),     64'h0000007877);
        check("bp_group_count", 64'(bus.count), 64'd2);
        check("bp_group_c",     64'(bus.c),     64'd1);
        tick();
        check_idle("bp_group_release");

        // Reset mid-fill discards three beats; a beat during rst is dropped
        drive(1'b1, 8'hE1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hE2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hE3, 1'b0, 1'b0); tick();
        rst = 1'b1;
        drive(1'b1, 8'hEE, 1'b1, 1'b1); tick();
        rst = 1'b0;
        check_idle("rst_fill");
        bus.out_ready = 1'b0;
        for (int i = 0; i < M; i++) begin
            // in_last on the m-th beat behaves as a plain full close
            drive(1'b1, 8'(8'h10 + i), logic'(i == M - 1), logic'(i == M - 1));
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_fill_x",     64'(bus.x),         64'h1413121110);
        check("rst_fill_count", 64'(bus.count),     64'd5);
        check("rst_fill_c",     64'(bus.c),         64'd1);
        check("rst_fill_outv",  64'(bus.out_valid), 64'd1);

        // Reset while holding with out_ready low
        tick();
        check("hold_wait_outv", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_hold");

        // Throughput: one group every M+1 cycles with in_valid and out_ready high
        for (int i = 0; i <= M * GROUPS; i++) begin
            beats[i] = 8'($urandom_range(0, 255));
        end
        beats[M*GROUPS] = 8'h00;
        bus.out_ready = 1'b1;
        for (int g = 0; g < GROUPS; g++) begin
            exp_x = '0;
            for (int b = 0; b < M; b++) begin
                check("tp_in_ready", 64'(bus.in_ready), 64'd1);
                drive(1'b1, beats[g*M+b], 1'b0, 1'b0);
                exp_x[b*N +: N] = beats[g*M+b];
                tick();
                check("tp_out_valid", 64'(bus.out_valid), 64'(b == M - 1));
            end
            check("tp_x",     64'(bus.x),     64'(exp_x));
            check("tp_count", 64'(bus.count), 64'd5);
            // Next group's first beat is presented but must not land on release
            drive(1'b1, beats[(g+1)*M], 1'b0, 1'b0);
            tick();
            check("tp_rel_count", 64'(bus.count),     64'd0);
            check("tp_rel_outv",  64'(bus.out_valid), 64'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_idle("tp_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_collector.md
# operand_collector

Serial-to-parallel operand buffer that feeds the m-operand fast adder. It accepts n-bit operands one per beat over a valid/ready handshake and packs up to m of them into the adder's flat m·n-bit operand bus, zero-padding short groups. It also captures the carry-in, then holds the packed group stable until the downstream stage accepts it.

## Interface
- m, 5: operands per group; legal range m ≥ 3, matching the fast-adder minimum.
- n, 64: operand width in bits.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data, in_last and in_c are valid.
- in_ready  output  1  collector can accept a beat.
- in_data  input  n  operand.
- in_last  input  1  this beat closes the group early.
- in_c  input  1  carry-in; sampled only on the closing beat.
- out_valid  output  1  packed group available.
- out_ready  input  1  downstream accepts the group.
- x  output  m·n  packed operands; operand k is at x[k·n +: n].
- c  output  1  carry-in for the group.
- count  output  $clog2(m+1)  number of real operands in the group (1..m).

## Operation
- States:
  - FILL: out_valid=0, in_ready=1.
  - HOLD: out_valid=1, in_ready=0.
  - in_ready is combinationally !out_valid.
- Accept in FILL:
  - A beat is accepted on a clk edge with in_valid & in_ready & !rst.
  - The accepted beat writes in_data to slot `count` and increments count.
- Closing beat: an accepted beat where count == m-1 or in_last == 1.
  - On that edge, c ← in_c and the state moves to HOLD.
  - Unwritten slots remain zero.
- in_last on the m-th beat is identical to a plain full close.
- in_c on non-closing beats is ignored.
- HOLD:
  - x, c and count are frozen.
  - in_valid is ignored and no beat is accepted.
- Release: on an edge with out_valid & out_ready:
  - all slots clear to 0;
  - count ← 0, c ← 0;
  - state ← FILL.
- No input beat is accepted on the release edge, because in_ready=0 in HOLD.
- out_ready while in FILL has no effect.
- Reset, including mid-fill or in HOLD:
  - Any partial or held group is discarded.
  - Reset values: x=0, c=0, count=0, out_valid=0, state FILL; in_ready therefore 1.
  - An input beat presented in the rst cycle is not accepted.
- No arithmetic is performed. Operands are stored verbatim and count never exceeds m.

## Timing
- A group of k beats (k ≤ m) closing at edge T gives out_valid=1, x, c and count valid from T until the release edge.
- Latency from closing beat to output: 1 clock.
- out_valid stays high until handshake; x and c must not change while out_valid=1.
- The earliest next accepted beat is the edge after release.
- Maximum throughput: one m-operand group per m+1 cycles when in_valid and out_ready are held high.
- x, c, count and out_valid are registered outputs; in_ready is the only combinational output.

## Test plan
- Full group, m=5, n=8: send 0x01..0x05 back-to-back with in_c=1 on beat 5, out_ready=1.
  - x=0x0504030201, c=1, count=5.
  - out_valid is high for exactly 1 cycle, starting the cycle after beat 5.
  - in_ready is low that cycle and returns the next.
- Short group: send 0xAA then 0xBB with in_last=1, in_c=0.
  - x=0x000000BBAA, count=2, c=0.
- Backpressure: close a group with out_ready=0 for 10 cycles while in_valid=1 with changing data.
  - x, c and count stay constant, and in_ready=0 throughout.
  - After out_ready=1, exactly one release occurs and the first new beat lands in slot 0.
- Reset mid-fill: after 3 beats, assert rst for 1 cycle, then send 5 beats 0x10..0x14.
  - Output is x=0x1413121110, count=5; no residue from the first group.
- Reset in HOLD: assert rst while out_valid=1 with out_ready=0.
  - Next cycle: out_valid=0, x=0, count=0, in_ready=1.
- Throughput: continuous in_valid with random data and out_ready=1 for 20 groups.
  - One group every 6 cycles, each x equal to the packed input sequence, no beat lost or duplicated.
